fir_coeff_load_ctrl: RTL and testbench

//   Sequences FIR coefficient loads from the PPC-written software registers into a

---
 rtl/fir_coeff_load_ctrl.sv | 119 +++++++++++
 tb/tb_fir_coeff_load_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_coeff_load_ctrl.sv
// Coefficient load sequencer: moves software-written tap pairs into the shadow bank
// of a double-buffered FIR coefficient RAM and swaps banks on a frame sync after commit.
//
// state   | meaning
// IDLE    | waiting for a go toggle; bank swaps may happen here
// WR_EVEN | presenting the even tap at {idx,0} until the RAM accepts it
// WR_ODD  | presenting the odd tap at {idx,1}; acceptance completes the load
module fir_coeff_load_ctrl #(
    parameter int COEF_W = 16,
    parameter int ADDR_W = 5
) (
    input  logic              user_clk,
    input  logic              user_rst,
    input  logic [31:0]       coef_reg,
    input  logic [31:0]       ctrl_reg,
    input  logic              sync_in,
    input  logic              coef_rdy,
    output logic              coef_we,
    output logic [ADDR_W:0]   coef_addr,
    output logic [COEF_W-1:0] coef_data,
    output logic              coef_bank,
    output logic              active_bank,
    output logic [31:0]       status
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_EVEN = 2'd1,
        WR_ODD  = 2'd2
    } state_t;

    state_t              state;
    logic [1:0]          ctrl_q;
    logic                primed;
    logic [ADDR_W-1:0]   idx_q;
    logic [COEF_W-1:0]   odd_q;
    logic                commit_pending;
    logic                go_error;
    logic [15:0]         load_cnt;

    logic go_evt;
    logic commit_evt;
    logic busy;
    logic swap;
    logic ctrl_unused;

    // Toggle edges are ignored until ctrl_q holds a real post-reset sample.
    assign go_evt     = primed & (ctrl_reg[31] ^ ctrl_q[1]);
    assign commit_evt = primed & (ctrl_reg[30] ^ ctrl_q[0]);
    assign busy       = (state != IDLE);
    assign swap       = commit_pending & ~busy & sync_in;

    assign coef_bank   = ~active_bank;
    assign status      = {busy, commit_pending, go_error, 13'd0, load_cnt};
    assign ctrl_unused = ^ctrl_reg[29:ADDR_W];

    always_ff @(posedge user_clk or posedge user_rst) begin
        if (user_rst) begin
            state          <= IDLE;
            ctrl_q         <= 2'b00;
            primed         <= 1'b0;
            idx_q          <= '0;
            odd_q          <= '0;
            commit_pending <= 1'b0;
            go_error       <= 1'b0;
            load_cnt       <= 16'd0;
            active_bank    <= 1'b0;
            coef_we        <= 1'b0;
            coef_addr      <= '0;
            coef_data      <= '0;
        end else begin
            ctrl_q <= ctrl_reg[31:30];
            primed <= 1'b1;

            if (go_evt && busy)
                go_error <= 1'b1;

            // A commit arriving in the swap cycle is absorbed by that swap.
            if (swap) begin
                active_bank    <= ~active_bank;
                commit_pending <= 1'b0;
            end else if (commit_evt) begin
                commit_pending <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (go_evt) begin
                        idx_q     <= ctrl_reg[ADDR_W-1:0];
                        odd_q     <= coef_reg[COEF_W-1:0];
                        coef_we   <= 1'b1;
                        coef_addr <= {ctrl_reg[ADDR_W-1:0], 1'b0};
                        coef_data <= coef_reg[16 +: COEF_W];
                        state     <= WR_EVEN;
                    end
                end
                WR_EVEN: begin
                    if (coef_we && coef_rdy) begin
                        coef_addr <= {idx_q, 1'b1};
                        coef_data <= odd_q;
                        state     <= WR_ODD;
                    end
                end
                WR_ODD: begin
                    if (coef_we && coef_rdy) begin
                        coef_we  <= 1'b0;
                        load_cnt <= load_cnt + 16'd1;
                        state    <= IDLE;
                    end
                end
                default: begin
                    coef_we <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_coeff_load_ctrl.sv
// Bench for fir_coeff_load_ctrl: directed scenarios then random traffic, with a
// transaction-level model feeding a write scoreboard and a per-cycle status check.
module tb_fir_coeff_load_ctrl;

    localparam int COEF_W = 16;
    localparam int ADDR_W = 5;

    logic              user_clk = 1'b0;
    logic              user_rst = 1'b1;
    logic [31:0]       coef_reg = 32'd0;
    logic [31:0]       ctrl_reg = 32'h8000_0000;
    logic              sync_in  = 1'b0;
    logic              coef_rdy = 1'b0;
    logic              coef_we;
    logic [ADDR_W:0]   coef_addr;
    logic [COEF_W-1:0] coef_data;
    logic              coef_bank;
    logic              active_bank;
    logic [31:0]       status;

    fir_coeff_load_ctrl #(.COEF_W(COEF_W), .ADDR_W(ADDR_W)) dut (
        .user_clk    (user_clk),
        .user_rst    (user_rst),
        .coef_reg    (coef_reg),
        .ctrl_reg    (ctrl_reg),
        .sync_in     (sync_in),
        .coef_rdy    (coef_rdy),
        .coef_we     (coef_we),
        .coef_addr   (coef_addr),
        .coef_data   (coef_data),
        .coef_bank   (coef_bank),
        .active_bank (active_bank),
        .status      (status)
    );

    always #5 user_clk = ~user_clk;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [ADDR_W:0]   addr;
        logic [COEF_W-1:0] data;
        logic              bank;
    } wr_t;

    wr_t exp_q[$];

    // reference model: writes still owed by the current load, plus sticky flags
    int        m_left;
    bit        m_primed;
    bit [1:0]  m_prev;
    bit        m_pend, m_err, m_bank;
    bit [15:0] m_cnt;

    // model state as of the start of the current cycle, for the monitor
    bit        e_busy, e_pend, e_err, e_bank;
    bit [15:0] e_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic void model_reset();
        m_left   = 0;
        m_primed = 1'b0;
        m_prev   = 2'b00;
        m_pend   = 1'b0;
        m_err    = 1'b0;
        m_bank   = 1'b0;
        m_cnt    = 16'd0;
        exp_q.delete();
    endfunction

    function automatic void snapshot();
        e_busy = (m_left > 0);
        e_pend = m_pend;
        e_err  = m_err;
        e_bank = m_bank;
        e_cnt  = m_cnt;
    endfunction

    function automatic void model_step();
        bit  go, cm, bsy, swp;
        wr_t w;
        go  = m_primed && (ctrl_reg[31] != m_prev[1]);
        cm  = m_primed && (ctrl_reg[30] != m_prev[0]);
        bsy = (m_left > 0);
        swp = m_pend && !bsy && sync_in;
        if (swp) begin
            m_bank = !m_bank;
            m_pend = 1'b0;
        end else if (cm) begin
            m_pend = 1'b1;
        end
        if (bsy && coef_rdy) begin
            m_left--;
            if (m_left == 0) m_cnt++;
        end
        if (go) begin
            if (bsy) begin
                m_err = 1'b1;
            end else begin
                m_left = 2;
                w.addr = {ctrl_reg[ADDR_W-1:0], 1'b0};
                w.data = coef_reg[31:16];
                w.bank = !m_bank;
                exp_q.push_back(w);
                w.addr = {ctrl_reg[ADDR_W-1:0], 1'b1};
                w.data = coef_reg[15:0];
                exp_q.push_back(w);
            end
        end
        m_prev   = ctrl_reg[31:30];
        m_primed = 1'b1;
    endfunction

    // One clock cycle of stimulus; inputs change just after the rising edge.
    task automatic drive(input bit rst, input bit go_t, input bit cm_t,
                         input logic [ADDR_W-1:0] idx, input logic [31:0] coef,
                         input bit sync, input bit rdy);
        logic [24:0] mid;
        @(posedge user_clk);
        #1;
        snapshot();
        mid      = 25'($urandom);
        user_rst = rst;
        ctrl_reg = {ctrl_reg[31] ^ go_t, ctrl_reg[30] ^ cm_t, mid, idx};
        coef_reg = coef;
        sync_in  = sync;
        coef_rdy = rdy;
        if (user_rst) begin
            model_reset();
            snapshot();
        end else begin
            model_step();
        end
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0, rdy);
    endtask

    // monitor: mid-cycle compare of every output against the model
    always @(negedge user_clk) begin
        check("status", status, {e_busy, e_pend, e_err, 13'd0, e_cnt});
        check("active_bank", {31'd0, active_bank}, {31'd0, e_bank});
        check("coef_bank", {31'd0, coef_bank}, {31'd0, ~e_bank});
        check("coef_we", {31'd0, coef_we}, {31'd0, e_busy});
        if (coef_we) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL wr_unexpected: addr %h data %h with empty queue", coef_addr, coef_data);
            end else begin
                check("wr_addr", {26'd0, coef_addr}, {26'd0, exp_q[0].addr});
                check("wr_data", {16'd0, coef_data}, {16'd0, exp_q[0].data});
                check("wr_bank", {31'd0, coef_bank}, {31'd0, exp_q[0].bank});
                if (coef_rdy) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        model_reset();
        snapshot();

        // toggle bit left high across reset must not start a load
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        idle(5, 1'b1);
        #2 check("no_load_after_reset", status, 32'd0);

        // clean reset with ctrl=0, then the reference load 0x1234_ABCD at pair 3
        drive(1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h1234_ABCD, 1'b0, 1'b1);
        idle(3, 1'b1);
        #2 check("load_cnt_one", status, 32'd1);

        // even write stalled four cycles, completing on first rdy
        drive(1'b0, 1'b1, 1'b0, 5'd3, 32'h1234_ABCD, 1'b0, 1'b0);
        idle(4, 1'b0);
        idle(4, 1'b1);

        // second go during WR_ODD is ignored and flagged
        drive(1'b0, 1'b1, 1'b0, 5'd9, 32'h5A5A_0F0F, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 5'd17, 32'hDEAD_BEEF, 1'b0, 1'b1);
        idle(4, 1'b1);
        #2 check("go_error_cnt", status, 32'h2000_0003);

        // commit during a load; sync while busy is ignored, later sync swaps
        drive(1'b0, 1'b1, 1'b0, 5'd1, 32'h1111_2222, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        idle(2, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        idle(2, 1'b1);
        #2 check("swapped_bank", {31'd0, active_bank}, 32'd1);

        // go and commit together: swap waits for the load to finish
        drive(1'b0, 1'b1, 1'b1, 5'd30, 32'h7777_8888, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1);
        idle(2, 1'b1);

        // reset mid-load with a commit pending
        drive(1'b0, 1'b0, 1'b1, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b1, 1'b0, 5'd4, 32'h4444_5555, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0);
        #1;
        check("rst_we", {31'd0, coef_we}, 32'd0);
        check("rst_status", status, 32'd0);
        check("rst_bank", {31'd0, active_bank}, 32'd0);
        drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            bit rst_now;
            rst_now = ($urandom_range(0, 499) == 0);
            drive(rst_now,
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 9) == 0),
                  5'($urandom),
                  $urandom,
                  ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 9) < 7));
        end

        idle(6, 1'b1);
        @(negedge user_clk);
        #1 check("queue_drained", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
